// File: rtl/gpio_pkg.sv
// ============================================================================
// Module  : gpio_pkg
// Brief   : Shared constants for the GPIO input port register map.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_EDGE      = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN    = 2'd2;
  localparam logic [1:0] ADDR_PRESS_CNT = 2'd3;

  // Buttons are active-low, so "released" is the safe idle level.
  localparam logic BTN_DB_RST = 1'b1;
  localparam logic SW_DB_RST  = 1'b0;

  localparam int PRESS_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// Module  : input_debouncer
// Brief   : Single-bit 2-flop synchroniser plus stable-count debouncer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module input_debouncer #(
  parameter int   DEB_CYCLES = 250000,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic db_o,
  output logic fall_o
);

  localparam int             CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          w_done;

  assign w_done = (sync2_q != db_q) && (cnt_q == CNT_LAST);

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (w_done) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o   = db_q;
  // Asserted in the cycle before db_q drops so edge flags load on the same edge.
  assign fall_o = w_done & db_q;

endmodule

`default_nettype wire

// File: rtl/gpio_input_port.sv
// ============================================================================
// Module  : gpio_input_port
// Brief   : Bus-mapped switch/button input port with W1C press flags and IRQ.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_input_port
  import gpio_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int N_SW       = 10,
  parameter int N_BTN      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_in,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             cs,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             irq
);

  logic [N_SW-1:0]        w_sw_db;
  logic [N_SW-1:0]        w_sw_fall;
  logic [N_BTN-1:0]       w_btn_db;
  logic [N_BTN-1:0]       w_btn_fall;

  logic [N_BTN-1:0]       edge_q, edge_d;
  logic [N_BTN-1:0]       irq_en_q, irq_en_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [PRESS_CNT_W-1:0] w_press_inc;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            w_rd_mux;
  logic                   rvalid_q;
  logic                   irq_q;
  logic                   w_wr;
  logic                   w_rd;

  generate
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
      input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(SW_DB_RST)) u_deb (
        .clk   (clk),
        .reset (reset),
        .raw_i (sw_in[i]),
        .db_o  (w_sw_db[i]),
        .fall_o(w_sw_fall[i])
      );
    end
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(BTN_DB_RST)) u_deb (
        .clk   (clk),
        .reset (reset),
        .raw_i (btn_in[i]),
        .db_o  (w_btn_db[i]),
        .fall_o(w_btn_fall[i])
      );
    end
  endgenerate

  assign w_wr = cs & we;
  assign w_rd = cs & ~we;

  always_comb begin
    w_press_inc = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_press_inc = w_press_inc + PRESS_CNT_W'(w_btn_fall[i]);
    end

    // New presses are OR-ed in after the clear, so a coincident set survives.
    edge_d = edge_q;
    if (w_wr && addr == ADDR_EDGE) edge_d = edge_q & ~wdata[N_BTN-1:0];
    edge_d = edge_d | w_btn_fall;

    irq_en_d = irq_en_q;
    if (w_wr && addr == ADDR_IRQ_EN) irq_en_d = wdata[N_BTN-1:0];

    press_cnt_d = press_cnt_q + w_press_inc;
    if (w_wr && addr == ADDR_PRESS_CNT) press_cnt_d = w_press_inc;

    w_rd_mux = '0;
    case (addr)
      ADDR_DATA:      w_rd_mux = 32'({~w_btn_db, w_sw_db});
      ADDR_EDGE:      w_rd_mux = 32'(edge_q);
      ADDR_IRQ_EN:    w_rd_mux = 32'(irq_en_q);
      ADDR_PRESS_CNT: w_rd_mux = 32'(press_cnt_q);
      default:        w_rd_mux = '0;
    endcase

    rdata_d = w_rd ? w_rd_mux : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_q      <= '0;
      irq_en_q    <= '0;
      press_cnt_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      edge_q      <= edge_d;
      irq_en_q    <= irq_en_d;
      press_cnt_q <= press_cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= w_rd;
      irq_q       <= |(edge_q & irq_en_q);
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

  wire w_unused_ok = &{1'b0, wdata[31:N_BTN], w_sw_fall};

endmodule

`default_nettype wire

// File: tb/tb_gpio_input_port.sv
// ============================================================================
// Module  : tb_gpio_input_port
// Brief   : Directed self-checking bench for gpio_input_port (DEB_CYCLES=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gpio_input_port;

  localparam int DEB = 4;

  logic        clk;
  logic        reset;
  logic [9:0]  sw_in;
  logic [2:0]  btn_in;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  gpio_input_port #(.DEB_CYCLES(DEB), .N_SW(10), .N_BTN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw_in),
    .btn_in(btn_in),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rdata is valid.
  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check(tag, rdata, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; sw_in = '0; btn_in = 3'b111;
    cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #120;
    reset = 1'b1;
    @(negedge clk);

    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    bus_read(2'd0, 32'h0, "rst_data");
    @(negedge clk);
    check("rvalid_drop", 32'(rvalid), 32'd0);
    bus_read(2'd1, 32'h0, "rst_edge");
    bus_read(2'd3, 32'h0, "rst_cnt");

    // Switch debounce latency
    sw_in = 10'h2A5;
    wait_cycles(4);
    bus_read(2'd0, 32'h0, "sw_early");
    wait_cycles(2);
    bus_read(2'd0, 32'h2A5, "sw_settled");
    bus_write(2'd0, 32'hFFFF_FFFF);
    check("wr_no_rvalid", 32'(rvalid), 32'd0);
    bus_read(2'd0, 32'h2A5, "data_ro");

    // Bouncing button 1 -> single press
    btn_in = 3'b101; @(negedge clk);
    btn_in = 3'b111; @(negedge clk);
    btn_in = 3'b101; @(negedge clk);
    btn_in = 3'b111; @(negedge clk);
    btn_in = 3'b101;
    wait_cycles(12);
    bus_read(2'd1, 32'h2, "bounce_edge");
    bus_read(2'd3, 32'h1, "bounce_cnt");
    bus_read(2'd0, 32'hAA5, "data_btn1");
    check("irq_disabled", 32'(irq), 32'd0);

    // IRQ path
    bus_write(2'd1, 32'h7);
    bus_read(2'd1, 32'h0, "edge_w1c");
    bus_write(2'd2, 32'hFFFF_FFFA);
    bus_read(2'd2, 32'h2, "irq_en_rd");
    btn_in = 3'b111;
    wait_cycles(10);
    check("irq_idle", 32'(irq), 32'd0);
    btn_in = 3'b101;
    wait_cycles(6);
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    bus_write(2'd1, 32'h2);
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);

    // W1C coinciding with a new press: set wins
    btn_in = 3'b111;
    wait_cycles(10);
    btn_in = 3'b101;
    wait_cycles(5);
    bus_write(2'd1, 32'h2);
    @(negedge clk);
    check("irq_setwins", 32'(irq), 32'd1);
    bus_read(2'd1, 32'h2, "edge_setwins");
    bus_read(2'd3, 32'h3, "cnt_three");

    // Simultaneous presses and counter wrap
    btn_in = 3'b111;
    wait_cycles(10);
    force dut.press_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.press_cnt_q;
    @(negedge clk);
    btn_in = 3'b010;
    wait_cycles(10);
    bus_read(2'd3, 32'h1, "cnt_wrap");
    bus_read(2'd1, 32'h7, "edge_dual");
    bus_read(2'd0, 32'h16A5, "data_dual");

    // Counter clear coinciding with a press
    btn_in = 3'b111;
    wait_cycles(10);
    bus_write(2'd1, 32'h7);
    btn_in = 3'b110;
    wait_cycles(5);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, 32'h1, "cnt_clr_press");
    bus_read(2'd1, 32'h1, "edge_btn0");

    // Reset mid-debounce and mid-read
    btn_in = 3'b111;
    bus_write(2'd2, 32'h3);
    wait_cycles(10);
    check("irq_pre_rst", 32'(irq), 32'd1);
    sw_in = 10'h15A;
    wait_cycles(4);
    cs = 1'b1; we = 1'b0; addr = 2'd0;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    cs = 1'b0;
    wait_cycles(2);
    check("rst_held_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b1;
    wait_cycles(4);
    bus_read(2'd0, 32'h0, "rst_deb_restart");
    wait_cycles(2);
    bus_read(2'd0, 32'h15A, "rst_deb_done");
    bus_read(2'd1, 32'h0, "rst2_edge");
    bus_read(2'd2, 32'h0, "rst2_irq_en");
    bus_read(2'd3, 32'h0, "rst2_cnt");
    check("rst2_irq", 32'(irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
